// File: rtl/snake_pkg.sv
// Shared definitions for the snake game sequencer: direction codes, FSM
// encoding and playfield geometry used by the graph/datapath side.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_CHECK     = 3'd2,
        ST_EAT       = 3'd3,
        ST_WAIT_RAND = 3'd4,
        ST_WAIT_HIT  = 3'd5,
        ST_OVER      = 3'd6
    } state_e;

    localparam int         CELL_SIZE   = 25;
    localparam int         FIELD_X_MIN = 2;
    localparam int         FIELD_X_MAX = 602;
    localparam int         FIELD_Y_MIN = 2;
    localparam int         FIELD_Y_MAX = 477;
    localparam logic [9:0] FRUIT_INIT  = 10'd152;

    // Up/down and left/right differ only in the LSB of the code.
    function automatic dir_e opposite(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_bcd_counter4.sv
// Four-digit BCD incrementer (digit 0 in bits [3:0]); 9999 wraps to 0000.
module bcd_counter4 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] value
);

    logic [15:0] value_d;
    logic        carry;

    // NOTE: combinational blocks use blocking '=' with every output given a default first, so no latch is inferred.
    always_comb begin
        value_d = value;
        carry   = inc;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (value[i*4 +: 4] == 4'd9) begin
                    value_d[i*4 +: 4] = 4'd0;
                end else begin
                    value_d[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) value <= '0;
        else                value <= value_d;
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: move tick, direction commit, collision/eat decisions,
// score, length and fruit re-placement handshake with the random source.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV  = 8000000,
    parameter int MAX_SEG   = 20,
    parameter int MAX_RETRY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] dir_in,
    input  logic       head_on_fruit,
    input  logic       head_on_body,
    input  logic       rand_valid,
    input  logic [9:0] rand_x,
    input  logic [9:0] rand_y,
    input  logic       hit_valid,
    input  logic       body_hit,
    output logic       step,
    output logic [1:0] dir_out,
    output logic       grow,
    output logic       rand_req,
    output logic       query_valid,
    output logic [9:0] query_x,
    output logic [9:0] query_y,
    output logic       fruit_load,
    output logic [9:0] fruit_x,
    output logic [9:0] fruit_y,
    output logic [4:0] length,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] score3,
    output logic [3:0] score4,
    output logic       game_over,
    output logic [2:0] state
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int RTY_W = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    logic [4:0]       len_q, len_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [9:0]       qx_q, qx_d, qy_q, qy_d, fx_q, fx_d, fy_q, fy_d;
    logic             qv_q, qv_d, fl_q, fl_d;
    logic             score_inc, score_clr;
    logic [15:0]      score_bcd;
    logic             tick, can_grow, dir_ok;

    assign tick     = (state_q == ST_RUN) && (cnt_q == CNT_W'(TICK_DIV - 1));
    assign can_grow = (len_q < 5'(MAX_SEG));
    // Codes above 3 and exact reversals leave the heading unchanged.
    assign dir_ok   = (dir_in[3:2] == 2'b00) && (dir_e'(dir_in[1:0]) != opposite(dir_q));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        len_d     = len_q;
        retry_d   = retry_q;
        qx_d      = qx_q;
        qy_d      = qy_q;
        fx_d      = fx_q;
        fy_d      = fy_q;
        qv_d      = 1'b0;
        fl_d      = 1'b0;
        score_inc = 1'b0;
        score_clr = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (tick) begin
                    cnt_d   = '0;
                    if (dir_ok) dir_d = dir_e'(dir_in[1:0]);
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (head_on_body)       state_d = ST_OVER;
                else if (head_on_fruit) state_d = ST_EAT;
                else                    state_d = ST_RUN;
            end
            ST_EAT: begin
                score_inc = 1'b1;
                if (can_grow) len_d = len_q + 5'd1;
                retry_d   = '0;
                state_d   = ST_WAIT_RAND;
            end
            ST_WAIT_RAND: begin
                if (rand_valid) begin
                    qx_d    = rand_x;
                    qy_d    = rand_y;
                    qv_d    = 1'b1;
                    state_d = ST_WAIT_HIT;
                end
            end
            ST_WAIT_HIT: begin
                if (hit_valid) begin
                    // Out of retries: accept the colliding candidate rather than stall the game.
                    if (!body_hit || retry_q == RTY_W'(MAX_RETRY)) begin
                        fx_d    = qx_q;
                        fy_d    = qy_q;
                        fl_d    = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = ST_WAIT_RAND;
                    end
                end
            end
            ST_OVER: begin
                if (start) begin
                    score_clr = 1'b1;
                    len_d     = '0;
                    cnt_d     = '0;
                    dir_d     = DIR_RIGHT;
                    state_d   = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
            len_q   <= '0;
            retry_q <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            fx_q    <= FRUIT_INIT;
            fy_q    <= FRUIT_INIT;
            qv_q    <= 1'b0;
            fl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            len_q   <= len_d;
            retry_q <= retry_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            qv_q    <= qv_d;
            fl_q    <= fl_d;
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .reset (reset),
        .clear (score_clr),
        .inc   (score_inc),
        .value (score_bcd)
    );

    assign step        = tick;
    assign dir_out     = dir_q;
    assign grow        = (state_q == ST_EAT) && can_grow;
    assign rand_req    = (state_q == ST_WAIT_RAND);
    assign query_valid = qv_q;
    assign query_x     = qx_q;
    assign query_y     = qy_q;
    assign fruit_load  = fl_q;
    assign fruit_x     = fx_q;
    assign fruit_y     = fy_q;
    assign length      = len_q;
    assign score1      = score_bcd[3:0];
    assign score2      = score_bcd[7:4];
    assign score3      = score_bcd[11:8];
    assign score4      = score_bcd[15:12];
    assign game_over   = (state_q == ST_OVER);
    assign state       = state_q;

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Game sequencer for the VGA snake datapath.
- Owns the move tick, direction latching, collision/eat decisions, score, length and fruit re-placement.
- The datapath holds segment coordinates and reports head/fruit/body overlaps; this block decides when to step, grow, relocate fruit or stop.
- Sits between the keyboard/moveState decoder, the random-coordinate source and the graph/datapath block.

Parameters:
TICK_DIV, 8000000, clk cycles between snake steps (min 2)
MAX_SEG, 20, maximum body segments (length saturates here)
MAX_RETRY, 4, fruit placement retries before accepting a colliding candidate

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  level; begins a game from IDLE or OVER
dir_in  in  4  requested direction: 0 up, 1 down, 2 left, 3 right; other values ignored
head_on_fruit  in  1  datapath: head overlaps fruit (valid in CHECK)
head_on_body  in  1  datapath: head overlaps a live segment (valid in CHECK)
rand_valid  in  1  random source has a candidate
rand_x, rand_y  in  10 each  candidate fruit origin
hit_valid  in  1  datapath: query result valid
body_hit  in  1  datapath: queried candidate overlaps the snake
step  out  1  one-cycle pulse: datapath shifts body and moves head by dir_out
dir_out  out  2  committed direction
grow  out  1  one-cycle pulse: enable the next segment
rand_req  out  1  request a new candidate
query_valid  out  1  one-cycle pulse presenting query_x/query_y
query_x, query_y  out  10 each  candidate under test
fruit_load  out  1  one-cycle pulse: datapath loads fruit_x/fruit_y
fruit_x, fruit_y  out  10 each  fruit origin
length  out  5  live body segments, 0..MAX_SEG
score1..score4  out  4 each  BCD score, score1 is the LSD
game_over  out  1  high while in OVER
state  out  3  FSM state, for debug

Behaviour:
Reset values:
- State IDLE, all pulses 0, rand_req 0, dir_out 3, length 0, scores 0.
- fruit_x = fruit_y = 152, query_x/query_y 0, retry count 0, tick counter 0.
- Reset in any state, including mid-handshake, returns to these values on the next edge and drops rand_req.

States: IDLE, RUN, CHECK, EAT, WAIT_RAND, WAIT_HIT, OVER.
- IDLE: counter held at 0. start=1 -> RUN.
- RUN: counter increments. At TICK_DIV-1: counter -> 0, pulse step, commit dir_out, -> CHECK. start is ignored.
- Direction commit: the latest dir_in (0..3) sampled on the step cycle is committed, except an exact reversal of the current dir_out (0<->1, 2<->3). A reversal or a value >3 keeps dir_out unchanged.
- CHECK (the cycle after step): head_on_body -> OVER (priority over fruit). Else head_on_fruit -> EAT. Else -> RUN. The counter does not run outside RUN, so the step period is TICK_DIV+1 cycles when no eat occurs.
- EAT (1 cycle):
  - Score increments by one as a BCD ripple; 9999 wraps to 0000.
  - If length < MAX_SEG: pulse grow and length+1. At MAX_SEG there is no grow pulse, but the score still increments.
  - Clear the retry count, raise rand_req, -> WAIT_RAND.
- WAIT_RAND: rand_req held high. On rand_valid: latch the candidate into query_x/query_y, drop rand_req, pulse query_valid next cycle, -> WAIT_HIT.
- WAIT_HIT: wait for hit_valid; body_hit is ignored without it.
  - body_hit=0: pulse fruit_load with fruit_x/fruit_y = query, -> RUN.
  - body_hit=1 and retry < MAX_RETRY: retry+1, raise rand_req, -> WAIT_RAND.
  - body_hit=1 and retry = MAX_RETRY: load the candidate anyway, -> RUN.
- OVER: game_over=1, all pulses 0, score and length frozen. start=1 -> clear score, length, counter and dir_out (3) -> RUN in one transition; fruit position is kept.
- Ticks never accumulate: no step is issued while EAT/WAIT_RAND/WAIT_HIT are outstanding.
- step, grow, query_valid and fruit_load are each exactly one cycle wide and never coincide.

Decomposition:
- Shared package snake_pkg: direction codes (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3), state encoding, cell size 25, playfield limits (2/602, 2/477), initial fruit origin 152.
- One natural sub-module: bcd_counter4 (4-digit BCD incrementer with wrap, synchronous reset), reusable by the score display path.

Test Plan:
- TICK_DIV=4, start held 1 cycle, no hits -> step pulses at cycles 4, 9, 14 after RUN entry; dir_out stays 3.
- dir_out=3, dir_in=2 at step -> dir_out stays 3. dir_in=0 at the next step -> dir_out=0. dir_in=7 -> unchanged.
- head_on_fruit in CHECK, rand_valid after 3 cycles with (300,200), hit_valid & !body_hit -> grow 1 pulse, length 1, score 0001, fruit_load with fruit=(300,200), back to RUN.
- body_hit returned 5 times with MAX_RETRY=4 -> rand_req raised 5 times, 5th candidate loaded, no further request.
- Score preset to 9999 by 9999 eats (or backdoor), one more eat -> score 0000; at length 20, an eat -> length 20, no grow pulse.
- head_on_body and head_on_fruit both high in CHECK -> OVER, score unchanged. Then start -> RUN with score 0, length 0, dir_out 3. Reset asserted in WAIT_RAND -> IDLE next cycle, rand_req 0.
